// File: rtl/brisc_pkg.sv
// brisc_pkg
// Shared types and geometry for the data-cache stage.
//   result_src_e  : writeback-stage result selector carried down the pipe
//   cache_state_e : miss-handling FSM states
//   LINE_BITS / NUM_LINES and the derived offset / index / tag widths
//   describe the default direct-mapped cache for a 32-bit address.
package brisc_pkg;

    localparam int ADDR_BITS   = 32;
    localparam int LINE_BITS   = 128;
    localparam int NUM_LINES   = 4;
    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
    localparam int INDEX_BITS  = $clog2(NUM_LINES);
    localparam int TAG_BITS    = ADDR_BITS - OFFSET_BITS - INDEX_BITS;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_src_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } cache_state_e;

endpackage

// File: rtl/dcache.sv
// dcache
// Direct-mapped, write-back data cache storage with one read/write port.
// Ports:
//   clk, reset_ni        : clock, synchronous active-low reset (valid/dirty only)
//   addr_i               : access address (tag / index / offset)
//   access_i, store_i    : a load or store is presented; store_i selects store
//   byte_i, wdata_i      : byte vs word access, store data
//   fill_i, fill_line_i  : write a whole refilled line at addr_i's index
//   hit_o, rdata_o       : combinational hit and load data (byte sign-extended)
//   victim_dirty_o       : indexed line is valid and dirty
//   victim_addr_o        : line-aligned address of the indexed line
//   victim_line_o        : contents of the indexed line
module dcache
    import brisc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int LINE_BITS = brisc_pkg::LINE_BITS,
    parameter int NUM_LINES = brisc_pkg::NUM_LINES
) (
    input  logic                 clk,
    input  logic                 reset_ni,
    input  logic [XLEN-1:0]      addr_i,
    input  logic                 access_i,
    input  logic                 store_i,
    input  logic                 byte_i,
    input  logic [XLEN-1:0]      wdata_i,
    input  logic                 fill_i,
    input  logic [LINE_BITS-1:0] fill_line_i,
    output logic                 hit_o,
    output logic [XLEN-1:0]      rdata_o,
    output logic                 victim_dirty_o,
    output logic [XLEN-1:0]      victim_addr_o,
    output logic [LINE_BITS-1:0] victim_line_o
);

    localparam int OFF_W   = $clog2(LINE_BITS / 8);
    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int TAG_W   = XLEN - OFF_W - IDX_W;
    localparam int BSEL_W  = $clog2(XLEN / 8);
    localparam int WSEL_W  = OFF_W - BSEL_W;
    localparam int LBIT_W  = $clog2(LINE_BITS);

    logic [TAG_W-1:0]     tag_q   [NUM_LINES];
    logic [LINE_BITS-1:0] data_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic [WSEL_W-1:0]    wsel;
    logic [BSEL_W-1:0]    bsel;
    logic [LBIT_W-1:0]    word_lsb;
    logic [LBIT_W-1:0]    byte_lsb;
    logic [LINE_BITS-1:0] line;
    logic [XLEN-1:0]      word;
    logic [7:0]           byte_val;
    logic [LINE_BITS-1:0] store_line;
    logic                 store_we;

    assign idx  = addr_i[OFF_W +: IDX_W];
    assign tag  = addr_i[XLEN-1 -: TAG_W];
    assign wsel = addr_i[BSEL_W +: WSEL_W];
    assign bsel = addr_i[0 +: BSEL_W];

    // Bit positions inside the line: word select scaled by XLEN, byte by 8.
    assign word_lsb = {wsel, {($clog2(XLEN)){1'b0}}};
    assign byte_lsb = {wsel, bsel, 3'b000};

    assign line     = data_q[idx];
    assign word     = line[word_lsb +: XLEN];
    assign byte_val = line[byte_lsb +: 8];

    assign hit_o   = access_i & valid_q[idx] & (tag_q[idx] == tag);
    assign rdata_o = byte_i ? {{(XLEN-8){byte_val[7]}}, byte_val} : word;

    assign victim_dirty_o = valid_q[idx] & dirty_q[idx];
    assign victim_addr_o  = {tag_q[idx], idx, {OFF_W{1'b0}}};
    assign victim_line_o  = line;

    // A fill only happens on a miss, so it never coincides with a store hit;
    // the fill still takes priority to keep the single port unambiguous.
    assign store_we = hit_o & store_i & ~fill_i;

    always_comb begin
        store_line = line;
        if (byte_i) begin
            store_line[byte_lsb +: 8] = wdata_i[7:0];
        end else begin
            store_line[word_lsb +: XLEN] = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (store_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid_q qualifies them.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            data_q[idx] <= fill_line_i;
            tag_q[idx]  <= tag;
        end else if (store_we) begin
            data_q[idx] <= store_line;
        end
    end

endmodule

// File: rtl/cache_stage.sv
// cache_stage
// EX->C pipeline registers, data cache and miss-handling FSM.
// Ports:
//   clk, reset                       : clock, synchronous active-low reset
//   stall_in                         : hazard-unit stall, holds the EX->C registers
//   alu_res_in .. is_byte_in         : instruction fields from EX
//   alu_res_out .. result_src_out    : fields towards writeback, read_data_out is
//                                      the combinational load result
//   stall_out                        : cache busy (miss or transfer in flight)
//   mem_req_out/mem_we_out/mem_addr_out/mem_wdata_out : line transfer request
//   mem_ready_in, mem_rdata_in       : one-cycle completion pulse and refill data
module cache_stage
    import brisc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_BITS  = 5,
    parameter int LINE_BITS = brisc_pkg::LINE_BITS,
    parameter int NUM_LINES = brisc_pkg::NUM_LINES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_in,
    input  logic [XLEN-1:0]      alu_res_in,
    input  logic [XLEN-1:0]      pc_plus4_in,
    input  logic [XLEN-1:0]      write_data_in,
    input  logic [REG_BITS-1:0]  rd_in,
    input  logic                 reg_write_in,
    input  result_src_e          result_src_in,
    input  logic                 mem_read_in,
    input  logic                 mem_write_in,
    input  logic                 is_byte_in,
    output logic [XLEN-1:0]      alu_res_out,
    output logic [XLEN-1:0]      pc_plus4_out,
    output logic [XLEN-1:0]      read_data_out,
    output logic [REG_BITS-1:0]  rd_out,
    output logic                 reg_write_out,
    output result_src_e          result_src_out,
    output logic                 stall_out,
    output logic                 mem_req_out,
    output logic                 mem_we_out,
    output logic [XLEN-1:0]      mem_addr_out,
    output logic [LINE_BITS-1:0] mem_wdata_out,
    input  logic                 mem_ready_in,
    input  logic [LINE_BITS-1:0] mem_rdata_in
);

    localparam int OFF_W = $clog2(LINE_BITS / 8);

    logic [XLEN-1:0]     alu_res_q;
    logic [XLEN-1:0]     pc_plus4_q;
    logic [XLEN-1:0]     write_data_q;
    logic [REG_BITS-1:0] rd_q;
    logic                reg_write_q;
    result_src_e         result_src_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic                is_byte_q;

    cache_state_e        state_q;
    cache_state_e        state_d;

    logic                mem_access;
    logic                hit;
    logic                miss;
    logic                fill;
    logic                victim_dirty;
    logic [XLEN-1:0]     victim_addr;
    logic [LINE_BITS-1:0] victim_line;
    logic                capture;

    assign mem_access = mem_read_q | mem_write_q;
    assign miss       = mem_access & ~hit;

    // Busy on a miss, and for the whole transfer; the access becomes a hit
    // again only once the FSM is back in IDLE with the new line in place.
    assign stall_out = mem_access & (miss | (state_q != ST_IDLE));
    assign capture   = ~stall_in & ~stall_out;

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_res_q    <= '0;
            pc_plus4_q   <= '0;
            write_data_q <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            result_src_q <= result_src_e'(0);
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            is_byte_q    <= 1'b0;
        end else if (capture) begin
            alu_res_q    <= alu_res_in;
            pc_plus4_q   <= pc_plus4_in;
            write_data_q <= write_data_in;
            rd_q         <= rd_in;
            reg_write_q  <= reg_write_in;
            result_src_q <= result_src_in;
            mem_read_q   <= mem_read_in;
            mem_write_q  <= mem_write_in;
            is_byte_q    <= is_byte_in;
        end
    end

    assign alu_res_out    = alu_res_q;
    assign pc_plus4_out   = pc_plus4_q;
    assign rd_out         = rd_q;
    assign reg_write_out  = reg_write_q;
    assign result_src_out = result_src_q;

    dcache #(
        .XLEN      (XLEN),
        .LINE_BITS (LINE_BITS),
        .NUM_LINES (NUM_LINES)
    ) u_dcache (
        .clk            (clk),
        .reset_ni       (reset),
        .addr_i         (alu_res_q),
        .access_i       (mem_access),
        .store_i        (mem_write_q),
        .byte_i         (is_byte_q),
        .wdata_i        (write_data_q),
        .fill_i         (fill),
        .fill_line_i    (mem_rdata_in),
        .hit_o          (hit),
        .rdata_o        (read_data_out),
        .victim_dirty_o (victim_dirty),
        .victim_addr_o  (victim_addr),
        .victim_line_o  (victim_line)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request outputs depend only on state_q and the held pipeline
    // registers, so they stay stable until mem_ready_in arrives.
    always_comb begin
        state_d       = state_q;
        mem_req_out   = 1'b0;
        mem_we_out    = 1'b0;
        mem_addr_out  = '0;
        mem_wdata_out = '0;
        fill          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (miss) begin
                    state_d = victim_dirty ? ST_WRITEBACK : ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                mem_req_out   = 1'b1;
                mem_we_out    = 1'b1;
                mem_addr_out  = victim_addr;
                mem_wdata_out = victim_line;
                if (mem_ready_in) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                mem_req_out  = 1'b1;
                mem_addr_out = {alu_res_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                if (mem_ready_in) begin
                    fill    = reset;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_stage.sv
module tb_cache_stage;
    import brisc_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall_in;
    logic [31:0]   alu_res_in, pc_plus4_in, write_data_in;
    logic [4:0]    rd_in;
    logic          reg_write_in;
    result_src_e   result_src_in;
    logic          mem_read_in, mem_write_in, is_byte_in;
    logic [31:0]   alu_res_out, pc_plus4_out, read_data_out;
    logic [4:0]    rd_out;
    logic          reg_write_out;
    result_src_e   result_src_out;
    logic          stall_out, mem_req_out, mem_we_out;
    logic [31:0]   mem_addr_out;
    logic [127:0]  mem_wdata_out;
    logic          mem_ready_in;
    logic [127:0]  mem_rdata_in;

    int checks = 0;
    int errors = 0;
    int handshakes;

    always #5 clk = ~clk;

    cache_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall_in       (stall_in),
        .alu_res_in     (alu_res_in),
        .pc_plus4_in    (pc_plus4_in),
        .write_data_in  (write_data_in),
        .rd_in          (rd_in),
        .reg_write_in   (reg_write_in),
        .result_src_in  (result_src_in),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .is_byte_in     (is_byte_in),
        .alu_res_out    (alu_res_out),
        .pc_plus4_out   (pc_plus4_out),
        .read_data_out  (read_data_out),
        .rd_out         (rd_out),
        .reg_write_out  (reg_write_out),
        .result_src_out (result_src_out),
        .stall_out      (stall_out),
        .mem_req_out    (mem_req_out),
        .mem_we_out     (mem_we_out),
        .mem_addr_out   (mem_addr_out),
        .mem_wdata_out  (mem_wdata_out),
        .mem_ready_in   (mem_ready_in),
        .mem_rdata_in   (mem_rdata_in)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic mr, input logic mw, input logic byt,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic rw, input result_src_e rs,
                          input logic [31:0] pc4);
        mem_read_in   = mr;
        mem_write_in  = mw;
        is_byte_in    = byt;
        alu_res_in    = addr;
        write_data_in = wd;
        rd_in         = rd;
        reg_write_in  = rw;
        result_src_in = rs;
        pc_plus4_in   = pc4;
    endtask

    task automatic nop();
        set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, RES_ALU, 32'h0);
    endtask

    initial begin
        // Reset with live inputs: registers must still come up zero.
        reset = 1'b0; stall_in = 1'b0; mem_ready_in = 1'b0; mem_rdata_in = '0;
        set_ex(1'b1, 1'b0, 1'b0, 32'h55, 32'h66, 5'd9, 1'b1, RES_PC4, 32'h77);
        cyc(); cyc();
        chk("rst_alu_res", alu_res_out, 32'h0);
        chk("rst_pc4", pc_plus4_out, 32'h0);
        chk("rst_rd", rd_out, 5'd0);
        chk("rst_regwrite", reg_write_out, 1'b0);
        chk("rst_result_src", result_src_out, RES_ALU);
        chk("rst_stall", stall_out, 1'b0);
        chk("rst_mem_req", mem_req_out, 1'b0);
        nop();
        reset = 1'b1;
        cyc();
        $display("txn reset done");

        // Cold miss on LW 0x40, refill, then hit.
        set_ex(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 5'd5, 1'b1, RES_MEM, 32'h104);
        cyc(); nop();
        chk("lw40_stall", stall_out, 1'b1);
        chk("lw40_idle_req", mem_req_out, 1'b0);
        cyc();
        chk("lw40_refill_req", mem_req_out, 1'b1);
        chk("lw40_refill_we", mem_we_out, 1'b0);
        chk("lw40_refill_addr", mem_addr_out, 32'h40);
        mem_ready_in = 1'b1;
        mem_rdata_in = 128'h33333333_22222222_11111111_DEADBEEF;
        cyc();
        mem_ready_in = 1'b0;
        chk("lw40_data", read_data_out, 32'hDEADBEEF);
        chk("lw40_stall_drop", stall_out, 1'b0);
        chk("lw40_rd", rd_out, 5'd5);
        chk("lw40_src", result_src_out, RES_MEM);
        cyc();
        chk("lw40_next_rd", rd_out, 5'd0);
        $display("txn LW 0x40 miss+refill");

        // SB 0x80 -> 0x41, then LB 0x41 and word reads of the line.
        set_ex(1'b0, 1'b1, 1'b1, 32'h41, 32'h80, 5'd0, 1'b0, RES_ALU, 32'h108);
        cyc();
        chk("sb41_stall", stall_out, 1'b0);
        set_ex(1'b1, 1'b0, 1'b1, 32'h41, 32'h0, 5'd6, 1'b1, RES_MEM, 32'h10C);
        cyc();
        chk("lb41_stall", stall_out, 1'b0);
        chk("lb41_data", read_data_out, 32'hFFFFFF80);
        set_ex(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 5'd6, 1'b1, RES_MEM, 32'h110);
        cyc();
        chk("lw40_merged", read_data_out, 32'hDEAD80EF);
        set_ex(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 5'd6, 1'b1, RES_MEM, 32'h114);
        cyc();
        chk("lw44_data", read_data_out, 32'h11111111);
        nop();
        cyc();
        $display("txn SB/LB 0x41");

        // SW 0x8 evicts dirty 0x40 line, then refills line 0.
        set_ex(1'b0, 1'b1, 1'b0, 32'h8, 32'hCAFEF00D, 5'd0, 1'b0, RES_ALU, 32'h118);
        cyc(); nop();
        chk("sw8_stall", stall_out, 1'b1);
        cyc();
        chk("sw8_wb_req", mem_req_out, 1'b1);
        chk("sw8_wb_we", mem_we_out, 1'b1);
        chk("sw8_wb_addr", mem_addr_out, 32'h40);
        chk("sw8_wb_data", mem_wdata_out, 128'h33333333_22222222_11111111_DEAD80EF);
        mem_ready_in = 1'b1;
        cyc();
        mem_ready_in = 1'b0;
        chk("sw8_rf_we", mem_we_out, 1'b0);
        chk("sw8_rf_addr", mem_addr_out, 32'h0);
        mem_ready_in = 1'b1;
        mem_rdata_in = 128'h44444444_55555555_66666666_77777777;
        cyc();
        mem_ready_in = 1'b0;
        chk("sw8_hit_stall", stall_out, 1'b0);
        cyc();
        $display("txn SW 0x8 writeback+refill");

        // LW 0x100 evicts the dirty tag-0 line at index 0.
        set_ex(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 5'd7, 1'b1, RES_MEM, 32'h11C);
        cyc(); nop();
        chk("lw100_stall", stall_out, 1'b1);
        cyc();
        chk("lw100_wb_we", mem_we_out, 1'b1);
        chk("lw100_wb_addr", mem_addr_out, 32'h0);
        chk("lw100_wb_data", mem_wdata_out, 128'h44444444_CAFEF00D_66666666_77777777);
        mem_ready_in = 1'b1;
        cyc();
        chk("lw100_rf_req", mem_req_out, 1'b1);
        chk("lw100_rf_we", mem_we_out, 1'b0);
        chk("lw100_rf_addr", mem_addr_out, 32'h100);
        mem_rdata_in = 128'h0BADF00D_0C0FFEE0_12345678_9ABCDEF0;
        cyc();
        mem_ready_in = 1'b0;
        chk("lw100_data", read_data_out, 32'h9ABCDEF0);
        chk("lw100_stall_drop", stall_out, 1'b0);
        cyc();
        $display("txn LW 0x100 writeback+refill");

        // ALU instruction held by stall_in.
        set_ex(1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd3, 1'b1, RES_ALU, 32'h1004);
        cyc();
        chk("alu_res", alu_res_out, 32'h1234);
        chk("alu_pc4", pc_plus4_out, 32'h1004);
        stall_in = 1'b1;
        set_ex(1'b0, 1'b0, 1'b0, 32'h5678, 32'h0, 5'd9, 1'b1, RES_PC4, 32'h1008);
        cyc(); cyc();
        chk("hold_alu_res", alu_res_out, 32'h1234);
        chk("hold_rd", rd_out, 5'd3);
        chk("hold_src", result_src_out, RES_ALU);
        chk("hold_stall_out", stall_out, 1'b0);
        chk("hold_mem_req", mem_req_out, 1'b0);
        stall_in = 1'b0;
        cyc();
        chk("release_alu_res", alu_res_out, 32'h5678);
        nop();
        cyc();
        $display("txn ALU stall hold");

        // Clean-victim miss with ready delayed 10 cycles while stall_in is high.
        handshakes = 0;
        set_ex(1'b1, 1'b0, 1'b0, 32'h204, 32'h0, 5'd8, 1'b1, RES_MEM, 32'h120);
        cyc(); nop();
        chk("lw204_stall", stall_out, 1'b1);
        stall_in = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) begin
            chk("delay_req", mem_req_out, 1'b1);
            chk("delay_we", mem_we_out, 1'b0);
            chk("delay_addr", mem_addr_out, 32'h200);
            cyc();
        end
        mem_ready_in = 1'b1;
        mem_rdata_in = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
        if (mem_req_out) handshakes++;
        cyc();
        mem_ready_in = 1'b0;
        chk("lw204_data", read_data_out, 32'hC2C2C2C2);
        chk("lw204_stall_drop", stall_out, 1'b0);
        for (int i = 0; i < 3; i++) begin
            mem_ready_in = 1'b1;
            if (mem_req_out) handshakes++;
            cyc();
        end
        mem_ready_in = 1'b0;
        chk("lw204_one_write", handshakes, 1);
        stall_in = 1'b0;
        cyc();
        nop();
        cyc();
        $display("txn LW 0x204 delayed ready");

        // Reset in the middle of a refill abandons it.
        set_ex(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 5'd4, 1'b1, RES_MEM, 32'h124);
        cyc(); nop();
        cyc();
        chk("lw300_rf_req", mem_req_out, 1'b1);
        chk("lw300_rf_addr", mem_addr_out, 32'h300);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        mem_ready_in = 1'b1;
        mem_rdata_in = '1;
        cyc();
        mem_ready_in = 1'b0;
        chk("midrst_mem_req", mem_req_out, 1'b0);
        chk("midrst_stall", stall_out, 1'b0);
        set_ex(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 5'd4, 1'b1, RES_MEM, 32'h128);
        cyc(); nop();
        chk("postrst_miss", stall_out, 1'b1);
        cyc();
        chk("postrst_req", mem_req_out, 1'b1);
        chk("postrst_we", mem_we_out, 1'b0);
        chk("postrst_addr", mem_addr_out, 32'h200);
        reset = 1'b0;
        cyc();
        $display("txn reset mid-refill");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
